// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide scheduler: iterative multiplier plus radix-2 restoring divider.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiply (MULT_LAT is then ignored).
module muldiv_sched #(
    parameter int MULT_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mult,
    input  logic        ex_div,
    input  logic        ex_signed,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        id_hilo_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] a_q, a_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        neg_q, neg_d, rs_neg_q, rs_neg_d;

    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;
    logic [63:0] mul_mag, mul_res;
    logic [32:0] part, diff;
    logic        div_ge;

    assign rs_neg = ex_signed & ex_rs[31];
    assign rt_neg = ex_signed & ex_rt[31];
    assign rs_mag = rs_neg ? (~ex_rs + 32'd1) : ex_rs;
    assign rt_mag = rt_neg ? (~ex_rt + 32'd1) : ex_rt;

`ifndef MULDIV_FAST_MULT_EN
    // Retire enough multiplier bits per cycle to finish in MULT_LAT cycles.
    localparam int BPC = (32 + MULT_LAT - 1) / MULT_LAT;
    logic [63:0] pp [BPC];
    logic [63:0] step_sum;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
            assign pp[gi] = b_q[gi] ? (a_q << gi) : 64'd0;
        end
    endgenerate

    always_comb begin
        step_sum = '0;
        for (int i = 0; i < BPC; i++) step_sum = step_sum + pp[i];
    end

    assign mul_mag = acc_q + step_sum;
`else
    assign mul_mag = {32'd0, a_q[31:0]} * {32'd0, b_q};
`endif

    assign mul_res = neg_q ? (~mul_mag + 64'd1) : mul_mag;

    // Divider: a_q[31:0] shifts dividend bits out and quotient bits in; acc_q[31:0] is the remainder.
    assign part   = {acc_q[31:0], a_q[31]};
    assign diff   = part - {1'b0, b_q};
    assign div_ge = ~diff[32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            rs_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            rs_neg_q <= rs_neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ex_mult)                       state_d = S_MUL;
                else if (ex_div && ex_rt != 32'd0) state_d = S_DIV;
            end
`ifdef MULDIV_FAST_MULT_EN
            S_MUL:  state_d = S_IDLE;
`else
            S_MUL:  if (cnt_q == 5'd0) state_d = S_IDLE;
`endif
            S_DIV:  if (cnt_q == 5'd0) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        acc_d    = acc_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        rs_neg_d = rs_neg_q;
        case (state_q)
            S_IDLE: begin
                if (ex_mult || (ex_div && ex_rt != 32'd0)) begin
                    a_d      = {32'd0, rs_mag};
                    b_d      = rt_mag;
                    acc_d    = '0;
                    neg_d    = rs_neg ^ rt_neg;
                    rs_neg_d = rs_neg;
                    cnt_d    = ex_mult ? 5'(MULT_LAT - 1) : 5'd31;
                end else if (ex_div) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = ex_rs;
                end else begin
                    if (ex_mthi) hi_d = ex_rs;
                    if (ex_mtlo) lo_d = ex_rs;
                end
            end
            S_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
                {hi_d, lo_d} = mul_res;
`else
                acc_d = mul_mag;
                a_d   = a_q << BPC;
                b_d   = b_q >> BPC;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) {hi_d, lo_d} = mul_res;
`endif
            end
            S_DIV: begin
                a_d   = {a_q[63:32], a_q[30:0], div_ge};
                acc_d = {acc_q[63:32], div_ge ? diff[31:0] : part[31:0]};
                cnt_d = cnt_q - 5'd1;
            end
            S_FIX: begin
                lo_d = neg_q    ? (~a_q[31:0] + 32'd1)   : a_q[31:0];
                hi_d = rs_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        stall = busy & id_hilo_use;
        hi    = hi_q;
        lo    = lo_q;
    end
endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed vector table, reset/MTxx sequences,
// and random ops checked against a plain-arithmetic HI/LO model.
module tb_muldiv_sched;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MLAT = 1;
`else
    localparam int MLAT = 4;
`endif

    logic        clk, rst_n;
    logic        ex_mult, ex_div, ex_signed, ex_mthi, ex_mtlo, id_hilo_use;
    logic [31:0] ex_rs, ex_rt, hi, lo;
    logic        busy, stall;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] model_hi, model_lo;

    muldiv_sched #(.MULT_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mult(ex_mult), .ex_div(ex_div), .ex_signed(ex_signed),
        .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .id_hilo_use(id_hilo_use),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          kind;   // 0 mult, 1 div, 2 mthi, 3 mtlo, 4 mthi+mtlo
        bit          sgn;
        logic [31:0] rs, rt;
        bit          use_id;
        bit          junk;   // illegal EX pulses while busy
        bit          extra;  // also raise lower-priority strobes at start
        logic [31:0] eh, el;
        int          eb;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic ref_model(input int kind, input bit sgn, input logic [31:0] rs, rt,
                             input logic [31:0] h_in, l_in,
                             output logic [31:0] h, output logic [31:0] l, output int b);
        longint x, y, p;
        h = h_in; l = l_in; b = 0;
        case (kind)
            0: begin
                if (sgn) p = longint'($signed(rs)) * longint'($signed(rt));
                else     p = longint'({32'd0, rs}) * longint'({32'd0, rt});
                {h, l} = p;
                b = MLAT;
            end
            1: begin
                if (rt == 32'd0) begin
                    l = 32'hFFFF_FFFF; h = rs;
                end else if (sgn) begin
                    x = longint'($signed(rs)); y = longint'($signed(rt));
                    l = 32'(x / y); h = 32'(x % y); b = 33;
                end else begin
                    l = rs / rt; h = rs % rt; b = 33;
                end
            end
            2: h = rs;
            3: l = rs;
            default: begin h = rs; l = rs; end
        endcase
    endtask

    // Called #1 after a rising edge; returns at the same phase once the unit is idle.
    task automatic do_op(input string nm, input int kind, input bit sgn,
                         input logic [31:0] rs, rt, input bit use_id, input bit junk,
                         input bit extra, input logic [31:0] eh, el, input int eb);
        int nb;
        bit bad_stall;
        ex_mult   = (kind == 0);
        ex_div    = (kind == 1) || (extra && kind == 0);
        ex_mthi   = (kind == 2) || (kind == 4) || (extra && kind < 2);
        ex_mtlo   = (kind == 3) || (kind == 4) || (extra && kind < 2);
        ex_signed = sgn; ex_rs = rs; ex_rt = rt; id_hilo_use = use_id;
        @(posedge clk); #1;
        ex_mult = 0; ex_div = 0; ex_mthi = 0; ex_mtlo = 0;
        ex_rs = $urandom; ex_rt = $urandom;
        nb = 0; bad_stall = 0;
        while (busy && nb < 100) begin
            if (stall !== use_id) bad_stall = 1;
            if (junk && nb == 2) begin
                ex_mult = 1; ex_div = 1; ex_mthi = 1; ex_rs = 32'hDEAD_BEEF; ex_rt = 32'd5;
            end else begin
                ex_mult = 0; ex_div = 0; ex_mthi = 0;
            end
            nb++;
            @(posedge clk); #1;
        end
        ex_mult = 0; ex_div = 0; ex_mthi = 0; ex_mtlo = 0;
        #1;
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(eb));
        chk({nm, "_stall_while_busy"}, 64'(bad_stall), 64'd0);
        chk({nm, "_stall_after"}, 64'(stall), 64'd0);
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        $display("[TB] op %s kind=%0d rs=%h rt=%h hi=%h lo=%h busy_cycles=%0d",
                 nm, kind, rs, rt, hi, lo, nb);
        id_hilo_use = 0;
        model_hi = eh; model_lo = el;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] eh, el, rs, rt;
        int eb, kind;
        bit sgn;

        vecs[0]  = '{"multu_max",   0, 0, 32'hFFFF_FFFF, 32'd2,        1, 0, 0, 32'd1,        32'hFFFF_FFFE, MLAT};
        vecs[1]  = '{"div_m7_2",    1, 1, 32'hFFFF_FFF9, 32'd2,        1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[2]  = '{"divu_7_2",    1, 0, 32'd7,         32'd2,        0, 0, 0, 32'd1,        32'd3,         33};
        vecs[3]  = '{"div_by_0",    1, 1, 32'h1234,      32'd0,        1, 0, 0, 32'h1234,     32'hFFFF_FFFF, 0};
        vecs[4]  = '{"div_ovf",     1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 32'd0,       32'h8000_0000, 33};
        vecs[5]  = '{"mult_m3_5",   0, 1, 32'hFFFF_FFFD, 32'd5,        0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MLAT};
        vecs[6]  = '{"div_7_m2",    1, 1, 32'd7,         32'hFFFF_FFFE, 1, 1, 0, 32'd1,       32'hFFFF_FFFD, 33};
        vecs[7]  = '{"prio_mult",   0, 0, 32'd3,         32'd5,        0, 0, 1, 32'd0,        32'd15,        MLAT};
        vecs[8]  = '{"mult_minmin", 0, 1, 32'h8000_0000, 32'h8000_0000, 1, 0, 0, 32'h4000_0000, 32'd0,       MLAT};
        vecs[9]  = '{"divu_big",    1, 0, 32'hFFFF_FFFF, 32'd1,        0, 0, 0, 32'd0,        32'hFFFF_FFFF, 33};
        vecs[10] = '{"prio_div0",   1, 0, 32'hABCD,      32'd0,        0, 0, 1, 32'hABCD,     32'hFFFF_FFFF, 0};

        rst_n = 0; ex_mult = 0; ex_div = 0; ex_signed = 0; ex_mthi = 0; ex_mtlo = 0;
        ex_rs = 0; ex_rt = 0; id_hilo_use = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        rst_n = 1; id_hilo_use = 0;
        model_hi = 0; model_lo = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            do_op(vecs[i].nm, vecs[i].kind, vecs[i].sgn, vecs[i].rs, vecs[i].rt,
                  vecs[i].use_id, vecs[i].junk, vecs[i].extra, vecs[i].eh, vecs[i].el, vecs[i].eb);

        do_op("mthi_a5", 2, 0, 32'hA5, 32'd0, 0, 0, 0, 32'hA5, model_lo, 0);
        do_op("mtlo_5a", 3, 0, 32'h5A, 32'd0, 0, 0, 0, model_hi, 32'h5A, 0);
        do_op("mthilo", 4, 0, 32'h1357_9BDF, 32'd0, 0, 0, 0, 32'h1357_9BDF, 32'h1357_9BDF, 0);

        // Reset held for two edges in the middle of a divide
        ex_div = 1; ex_signed = 0; ex_rs = 32'd100; ex_rt = 32'd7; id_hilo_use = 1;
        @(posedge clk); #1;
        ex_div = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("middiv_busy_before_reset", 64'(busy), 64'd1);
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("middiv_reset_hi", 64'(hi), 64'd0);
        chk("middiv_reset_lo", 64'(lo), 64'd0);
        chk("middiv_reset_busy", 64'(busy), 64'd0);
        chk("middiv_reset_stall", 64'(stall), 64'd0);
        rst_n = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("middiv_discarded_lo", 64'(lo), 64'd0);
        chk("middiv_discarded_busy", 64'(busy), 64'd0);
        id_hilo_use = 0;
        model_hi = 0; model_lo = 0;

        for (int n = 0; n < 40; n++) begin
            kind = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 4));
            sgn = 1'($urandom);
            rs = $urandom;
            case ($urandom_range(0, 7))
                0:       rt = 32'd0;
                1:       rt = $urandom_range(1, 9);
                2:       rt = 32'hFFFF_FFFF;
                default: rt = $urandom;
            endcase
            ref_model(kind, sgn, rs, rt, model_hi, model_lo, eh, el, eb);
            do_op($sformatf("rand%0d", n), kind, sgn, rs, rt, 1'($urandom), 0, 0, eh, el, eb);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
